// File: rtl/nr_inv_sqrt_iter.sv
// nr_inv_sqrt_iter: iterative Newton-Raphson refinement of 1/sqrt(x) on unsigned Q(INT,F) words.
// Define NR_INV_SQRT_ROUND_EN to round (half up) instead of truncate when rescaling each step.
module nr_inv_sqrt_iter #(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4,
  parameter int ITERATIONS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] y0,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] y,
  output logic                             zero_err
);
  localparam int W = INT_WIDTH + FRACT_WIDTH;
  localparam int F = FRACT_WIDTH;
  localparam logic [3*W-1:0] THREE_HALVES = (3*W)'(3) << (3*F-1);
`ifdef NR_INV_SQRT_ROUND_EN
  localparam logic [4*W-1:0] RND = (4*W)'(1) << (3*F-1);
`else
  localparam logic [4*W-1:0] RND = '0;
`endif
  typedef enum logic [1:0] {IDLE, CALC_A, CALC_Y, DONE} state_t;
  state_t         state;
  logic [W-1:0]   xr, yc, y_next;
  logic [3*W-1:0] a, prod3, b;
  logic [4*W-1:0] p, q;
  logic [3:0]     cnt, cnt_n;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    prod3  = (3*W)'(xr) * (3*W)'(yc) * (3*W)'(yc);
    b      = a > THREE_HALVES ? '0 : THREE_HALVES - a;
    p      = (4*W)'(yc) * (4*W)'(b) + RND;
    q      = p >> (3*F);
    y_next = |q[4*W-1:W] ? '1 : q[W-1:0];
    cnt_n  = cnt + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      xr       <= '0;
      yc       <= '0;
      a        <= '0;
      cnt      <= '0;
      y        <= '0;
      zero_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr  <= x;
          yc  <= y0;
          cnt <= '0;
          if (x == '0) begin
            y        <= '1;
            zero_err <= 1'b1;
            state    <= DONE;
          end else begin
            state <= CALC_A;
          end
        end
        CALC_A: begin
          a     <= prod3 >> 1;
          state <= CALC_Y;
        end
        CALC_Y: begin
          yc  <= y_next;
          cnt <= cnt_n;
          if (cnt_n < 4'(ITERATIONS)) begin
            state <= CALC_A;
          end else begin
            y        <= y_next;
            zero_err <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nr_inv_sqrt_iter.sv
// tb_nr_inv_sqrt_iter: directed vectors with hand-computed results for nr_inv_sqrt_iter.
module tb_nr_inv_sqrt_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y0 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] y;
  logic        zero_err;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  nr_inv_sqrt_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y0(y0), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero_err(zero_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Offers one operand, scrambles inputs after accept, then checks latency (edges after the accept edge) and result.
  task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                        input logic [15:0] ey, input logic ez, input int elat, input logic take);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    x = xv;
    y0 = yv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    x = 16'hA5A5;
    y0 = 16'h5A5A;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(elat));
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_zero"}, 32'(zero_err), 32'(ez));
    if (take) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_drop"}, 32'(out_valid), 32'd0);
    end
  endtask
  initial begin
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_zero", 32'(zero_err), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready", 32'(in_ready), 32'd1);
    run_op("x4_y05", 16'h0040, 16'h0008, 16'h0008, 1'b0, 4, 1'b1);
`ifdef NR_INV_SQRT_ROUND_EN
    run_op("x4_y7", 16'h0040, 16'h0007, 16'h0008, 1'b0, 4, 1'b1);
    run_op("x1_yE", 16'h0010, 16'h000E, 16'h0010, 1'b0, 4, 1'b1);
`else
    run_op("x4_y7", 16'h0040, 16'h0007, 16'h0007, 1'b0, 4, 1'b1);
    run_op("x1_yE", 16'h0010, 16'h000E, 16'h000F, 1'b0, 4, 1'b1);
`endif
    run_op("xzero", 16'h0000, 16'h0010, 16'hFFFF, 1'b1, 0, 1'b1);
    run_op("clamp", 16'h0100, 16'h0010, 16'h0000, 1'b0, 4, 1'b1);
    run_op("y0zero", 16'h0040, 16'h0000, 16'h0000, 1'b0, 4, 1'b1);
    run_op("x1_y1", 16'h0010, 16'h0010, 16'h0010, 1'b0, 4, 1'b1);
    // Backpressure in DONE with a competing offer on the input.
    run_op("hold", 16'h0040, 16'h0008, 16'h0008, 1'b0, 4, 1'b0);
    x = 16'h0100;
    y0 = 16'h0010;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_y", 32'(y), 32'h0008);
      check("hold_inrdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("rel_valid", 32'(out_valid), 32'd0);
    check("rel_inrdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("acc_inrdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("acc_early", 32'(out_valid), 32'd0);
    step();
    check("acc_valid", 32'(out_valid), 32'd1);
    check("acc_y", 32'(y), 32'h0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    // Reset landing in CALC_Y of the first iteration, after y was left nonzero.
    run_op("pre", 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 0, 1'b1);
    x = 16'h0040;
    y0 = 16'h0008;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_y", 32'(y), 32'd0);
    check("mid_zero", 32'(zero_err), 32'd0);
    check("mid_inrdy", 32'(in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_idle", 32'(out_valid), 32'd0);
    end
    run_op("fresh", 16'h0040, 16'h0008, 16'h0008, 1'b0, 4, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
